uart_tx_arbiter: RTL

Shares the single UART transmitter between NREQ byte-stream requesters, for example the echo path and a status/report source. Round-robin arbitration operates at packet granularity: a grant is held until the requester's byte flagged last has been fully shifted out. The block sits between the requesters and the UART TX core and sequences the core via a start/busy interface.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter_if                                               |
// | Requester byte streams plus UART TX core start/busy handshake.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [NREQ-1:0]   grant;
    logic              timeout_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter                                                  |
// | Packet-granular round-robin sharing of one UART TX core.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NREQ         = 2,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SEND    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_HI = 2'd2;
    localparam logic [1:0] c_ST_WAIT_LO = 2'd3;

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_grant;
    logic [c_IW-1:0] r_gidx;
    logic [c_IW-1:0] r_ptr;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_hi_cnt;
    logic            r_last;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic [NREQ-1:0] r_req_ready;
    logic            r_timeout_err;

    logic [c_IW-1:0] w_sel;
    logic            w_any;
    logic            w_g_valid;
    logic [7:0]      w_g_data;
    logic            w_g_last;

    // Search order starts just after the last owner so it cannot win a tie.
    always_comb begin
        int j;
        logic [c_IW-1:0] idx;
        j     = 0;
        idx   = '0;
        w_sel = '0;
        w_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = c_IW'(j);
            if (!w_any && bus.req_valid[idx]) begin
                w_any = 1'b1;
                w_sel = idx;
            end
        end
    end

    assign w_g_valid = bus.req_valid[r_gidx];
    assign w_g_data  = bus.req_data[{r_gidx, 3'b000} +: 8];
    assign w_g_last  = bus.req_last[r_gidx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_ptr         <= c_IW'(NREQ - 1);
            r_cnt         <= '0;
            r_hi_cnt      <= '0;
            r_last        <= 1'b0;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_req_ready   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_req_ready   <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_gidx  <= w_sel;
                        r_grant <= NREQ'(1) << w_sel;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (w_g_valid && !bus.tx_busy) begin
                        r_req_ready <= NREQ'(1) << r_gidx;
                        r_tx_start  <= 1'b1;
                        r_tx_data   <= w_g_data;
                        r_last      <= w_g_last;
                        r_cnt       <= '0;
                        r_hi_cnt    <= '0;
                        r_state     <= c_ST_WAIT_HI;
                    end else if (!w_g_valid) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_grant       <= '0;
                            r_ptr         <= r_gidx;
                            r_cnt         <= '0;
                            r_state       <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_CW'(1);
                        end
                    end
                end
                c_ST_WAIT_HI: begin
                    // A core that never reports busy must not stall the arbiter.
                    if (bus.tx_busy || r_hi_cnt == 2'd2) begin
                        r_state <= c_ST_WAIT_LO;
                    end else begin
                        r_hi_cnt <= r_hi_cnt + 2'd1;
                    end
                end
                c_ST_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= r_gidx;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_SEND;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.req_ready   = r_req_ready;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire
